dmem_responder: RTL and testbench

//  Data-memory responder for the multicycle CPU's load/store request interface.

---
 rtl/dmem_responder_pkg.sv | 13 +
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder:
// FSM state encodings and wait-counter width.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: 2**ADDR_W x 32,
// synchronous write (we/idx/wdata), asynchronous read (idx -> rdata).
module dmem_array #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store in IDLE, waits LATENCY
// cycles, then pulses ready with rd. Ports: clk, rst (async active-low),
// req/we/addr/wd in; busy/ready/rd/err out.
// Optional DMEM_MISALIGN_ERR_EN: misaligned requests flag err, no access.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rd,
    output logic        err
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [31:0]        wd_q, wd_d;
    logic               mis_q, mis_d;
    logic               ready_q, ready_d;
    logic [31:0]        rd_q, rd_d;
    logic               err_q, err_d;

    // Access performed on the edge entering RESP. With zero latency that
    // edge is the accept edge, so the live inputs are used directly.
    logic               enter_resp;
    logic               acc_we;
    logic [ADDR_W-1:0]  acc_idx;
    logic [31:0]        acc_wd;
    logic               acc_mis;
    logic               blocked;
    logic               mem_we;
    logic [31:0]        mem_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        mis_d      = mis_q;
        enter_resp = 1'b0;
        acc_we     = we_q;
        acc_idx    = idx_q;
        acc_wd     = wd_q;
        acc_mis    = mis_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d  = we;
                    idx_d = addr[ADDR_W+1:2];
                    wd_d  = wd;
                    mis_d = (addr[1:0] != 2'b00);
                    cnt_d = LAT_C;
                    if (LATENCY == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        acc_we     = we;
                        acc_idx    = addr[ADDR_W+1:2];
                        acc_wd     = wd;
                        acc_mis    = (addr[1:0] != 2'b00);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    assign blocked = acc_mis;
`else
    logic unused_mis;
    assign unused_mis = acc_mis;
    assign blocked    = 1'b0;
`endif

    assign mem_we  = enter_resp & acc_we & ~blocked;
    assign rd_d    = (enter_resp & ~acc_we & ~blocked) ? mem_rdata : rd_q;
    assign err_d   = enter_resp & blocked;
    assign ready_d = enter_resp;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (acc_idx),
        .wdata (acc_wd),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wd_q    <= '0;
            mis_q   <= 1'b0;
            ready_q <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            mis_q   <= mis_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Upper address bits are dropped so accesses wrap modulo depth.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W+2];

    assign busy  = (state_q != ST_IDLE);
    assign ready = ready_q;
    assign rd    = rd_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance (dut)
// and LATENCY=0 instance (dut0).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wd = '0;
    logic        busy, ready, err;
    logic [31:0] rd;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic        busy0, ready0, err0;
    logic [31:0] rd0;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

`ifdef DMEM_MISALIGN_ERR_EN
    localparam logic        MIS_ERR = 1'b1;
    localparam logic [31:0] MIS_RD  = 32'hCAFE_F00D;
`else
    localparam logic        MIS_ERR = 1'b0;
    localparam logic [31:0] MIS_RD  = 32'hFFFF_FFFF;
`endif

    dmem_responder #(.ADDR_W(6), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd),
        .busy(busy), .ready(ready), .rd(rd), .err(err)
    );

    dmem_responder #(.ADDR_W(6), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wd(wd0),
        .busy(busy0), .ready(ready0), .rd(rd0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // LATENCY=2 request: ready expected at the negedge after edge k+2.
    task automatic req2(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic e_err,
                        output logic [31:0] r);
        @(negedge clk);
        chk("idle_before", 32'(busy), 32'd0);
        req = 1'b1; we = w; addr = a; wd = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = ~w; addr = $urandom; wd = $urandom;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("lat2_ready", 32'(ready), 32'(i == 2));
            chk("lat2_busy", 32'(busy), 32'd1);
            if (i == 2) begin
                chk("lat2_err", 32'(err), 32'(e_err));
                r = rd;
            end
        end
        @(negedge clk);
        chk("lat2_ready_drop", 32'(ready), 32'd0);
        chk("lat2_idle", 32'(busy), 32'd0);
        chk("lat2_rd_held", rd, r);
    endtask

    // LATENCY=0 request: ready at the negedge right after the accept edge.
    task automatic req0_t(input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        chk("lat0_idle_before", 32'(busy0), 32'd0);
        req0 = 1'b1; we0 = w; addr0 = a; wd0 = d;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; addr0 = $urandom; wd0 = $urandom;
        chk("lat0_ready", 32'(ready0), 32'd1);
        chk("lat0_busy", 32'(busy0), 32'd1);
        chk("lat0_err", 32'(err0), 32'd0);
        r = rd0;
        @(negedge clk);
        chk("lat0_ready_drop", 32'(ready0), 32'd0);
        chk("lat0_busy_drop", 32'(busy0), 32'd0);
    endtask

    logic [31:0] r;
    logic [31:0] tab [8] = '{32'h0, 32'h8, 32'hC, 32'h20,
                            32'h4, 32'h18, 32'h1C, 32'h0};

    initial begin
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;

        // Store then load the same word.
        req2(1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, r);
        chk("store_rd_unchanged", r, 32'd0);
        req2(1'b0, 32'h10, 32'h0, 1'b0, r);
        chk("load_10", r, 32'hCAFE_F00D);

        // Reset mid-WAIT discards the pending store.
        req2(1'b1, 32'h20, 32'hAAAA_0000, 1'b0, r);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_rd", rd, 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req2(1'b0, 32'h20, 32'h0, 1'b0, r);
        chk("rst_discard", r, 32'hAAAA_0000);

        // req held high with changing addr/wd: one pulse per accept.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; wd = 32'h0;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(ready), 32'(i == 2 || i == 6));
            chk("hold_busy", 32'(busy), 32'(!(i == 3 || i == 7)));
            if (i == 2) chk("hold_rd1", rd, 32'hCAFE_F00D);
            if (i == 6) chk("hold_rd2", rd, 32'hAAAA_0000);
            addr = tab[i];
            wd   = $urandom;
            req  = (i < 6);
        end
        req = 1'b0;

        // Address wrap modulo depth.
        req2(1'b1, 32'h100, 32'h1234_5678, 1'b0, r);
        req2(1'b0, 32'h0, 32'h0, 1'b0, r);
        chk("wrap_load", r, 32'h1234_5678);

        // Misaligned store.
        req2(1'b1, 32'h11, 32'hFFFF_FFFF, MIS_ERR, r);
        chk("mis_rd_unchanged", r, 32'h1234_5678);
        req2(1'b0, 32'h10, 32'h0, 1'b0, r);
        chk("mis_load_10", r, MIS_RD);

        // Zero-latency instance.
        req0_t(1'b1, 32'h4, 32'h0BAD_BEEF, r);
        chk("lat0_store_rd", r, 32'd0);
        req0_t(1'b0, 32'h4, 32'h0, r);
        chk("lat0_load", r, 32'h0BAD_BEEF);
        req0_t(1'b0, 32'h104, 32'h0, r);
        chk("lat0_wrap", r, 32'h0BAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
